// File: rtl/cmp_pkg.sv
// Shared mode encodings and the result payload for the pipelined comparator.
package cmp_pkg;

  localparam logic [1:0] MODE_UNS = 2'b00;
  localparam logic [1:0] MODE_TC  = 2'b01;
  localparam logic [1:0] MODE_SM  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef struct packed {
    logic ageb;
    logic aeqb;
    logic agtb;
    logic mode_err;
  } cmp_res_t;

endpackage

// File: rtl/cmp_norm.sv
// Maps a WIDTH-bit operand in the selected format onto a common (WIDTH+1)-bit
// two's-complement value so one signed compare covers every format.
module cmp_norm
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH:0]   norm_o
);

  localparam int unsigned NW = WIDTH + 1;

  logic [NW-1:0] mag_c;

  // Sign-magnitude negative zero naturally lands on 0 because -0 == 0.
  always_comb begin
    mag_c  = {2'b00, data_i[WIDTH-2:0]};
    norm_o = {1'b0, data_i};
    case (mode_i)
      MODE_TC: norm_o = {data_i[WIDTH-1], data_i};
      MODE_SM: norm_o = data_i[WIDTH-1] ? NW'(-mag_c) : mag_c;
      default: norm_o = {1'b0, data_i};
    endcase
  end

endmodule

// File: rtl/cmp_pipe_sm.sv
// Two-stage valid/ready comparator: stage 1 normalises, stage 2 compares.
// Optional retire statistics are built only when CMP_PIPE_STAT_EN is defined.
module cmp_pipe_sm
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAT_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WIDTH-1:0]  DataA,
  input  logic [WIDTH-1:0]  DataB,
  input  logic [1:0]        Mode,
  input  logic              InValid,
  output logic              InReady,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              AGEB,
  output logic              AEQB,
  output logic              AGTB,
  output logic              ModeErr,
  input  logic              StatClr,
  output logic [STAT_W-1:0] GeCount,
  output logic [STAT_W-1:0] TotCount
);

  localparam int unsigned NW = WIDTH + 1;

  logic [NW-1:0] na_c, nb_c;
  logic [NW-1:0] na_q, na_d, nb_q, nb_d;
  logic          s1_v_q, s1_v_d, err1_q, err1_d;
  logic          s2_v_q, s2_v_d;
  cmp_res_t      res_q, res_d;
  logic          s2_adv_c, s1_adv_c, in_xfer_c;

  cmp_norm #(.WIDTH(WIDTH)) u_norm_a (.data_i(DataA), .mode_i(Mode), .norm_o(na_c));
  cmp_norm #(.WIDTH(WIDTH)) u_norm_b (.data_i(DataB), .mode_i(Mode), .norm_o(nb_c));

  assign s2_adv_c  = !s2_v_q || OutReady;
  assign s1_adv_c  = !s1_v_q || s2_adv_c;
  assign in_xfer_c = InValid && s1_adv_c;

  always_comb begin
    s1_v_d = s1_v_q;
    na_d   = na_q;
    nb_d   = nb_q;
    err1_d = err1_q;
    s2_v_d = s2_v_q;
    res_d  = res_q;
    if (s1_adv_c) s1_v_d = InValid;
    if (in_xfer_c) begin
      na_d   = na_c;
      nb_d   = nb_c;
      err1_d = (Mode == MODE_RSV);
    end
    // Result register only reloads with a real item so a held result stays put.
    if (s2_adv_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        res_d.ageb     = ($signed(na_q) >= $signed(nb_q));
        res_d.aeqb     = (na_q == nb_q);
        res_d.agtb     = ($signed(na_q) > $signed(nb_q));
        res_d.mode_err = err1_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_v_q <= 1'b0;
      na_q   <= '0;
      nb_q   <= '0;
      err1_q <= 1'b0;
      s2_v_q <= 1'b0;
      res_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      na_q   <= na_d;
      nb_q   <= nb_d;
      err1_q <= err1_d;
      s2_v_q <= s2_v_d;
      res_q  <= res_d;
    end
  end

  assign InReady  = s1_adv_c;
  assign OutValid = s2_v_q;
  assign AGEB     = res_q.ageb;
  assign AEQB     = res_q.aeqb;
  assign AGTB     = res_q.agtb;
  assign ModeErr  = res_q.mode_err;

`ifdef CMP_PIPE_STAT_EN
  logic [STAT_W-1:0] ge_q, tot_q;
  logic              out_xfer_c;

  assign out_xfer_c = s2_v_q && OutReady;

  // Saturating retire counters; a clear beats a same-cycle increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ge_q  <= '0;
      tot_q <= '0;
    end else if (StatClr) begin
      ge_q  <= '0;
      tot_q <= '0;
    end else if (out_xfer_c) begin
      if (tot_q != '1) tot_q <= tot_q + STAT_W'(1);
      if (res_q.ageb && (ge_q != '1)) ge_q <= ge_q + STAT_W'(1);
    end
  end

  assign GeCount  = ge_q;
  assign TotCount = tot_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = StatClr;
  assign GeCount  = '0;
  assign TotCount = '0;
`endif

endmodule

// File: tb/tb_cmp_pipe_sm.sv
// Scoreboard bench for cmp_pipe_sm (WIDTH=8); stats checks follow CMP_PIPE_STAT_EN.
module tb_cmp_pipe_sm;
  import cmp_pkg::*;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAT_W = 16;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [WIDTH-1:0]  DataA, DataB;
  logic [1:0]        Mode;
  logic              InValid, InReady, OutValid, OutReady;
  logic              AGEB, AEQB, AGTB, ModeErr, StatClr;
  logic [STAT_W-1:0] GeCount, TotCount;
  logic [3:0]        obs;

  int checks = 0;
  int failures = 0;
  int n_retired = 0;
  cmp_res_t exp_q[$];

  cmp_pipe_sm #(.WIDTH(WIDTH), .STAT_W(STAT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .DataA(DataA), .DataB(DataB), .Mode(Mode),
    .InValid(InValid), .InReady(InReady), .OutValid(OutValid), .OutReady(OutReady),
    .AGEB(AGEB), .AEQB(AEQB), .AGTB(AGTB), .ModeErr(ModeErr),
    .StatClr(StatClr), .GeCount(GeCount), .TotCount(TotCount)
  );

`ifdef CMP_PIPE_STAT_EN
  logic       s_ir, s_ov, s_ge, s_eq, s_gt, s_err;
  logic [1:0] s_gec, s_totc;
  cmp_pipe_sm #(.WIDTH(WIDTH), .STAT_W(2)) dut_sat (
    .CLK(CLK), .RST_N(RST_N), .DataA(DataA), .DataB(DataB), .Mode(Mode),
    .InValid(InValid), .InReady(s_ir), .OutValid(s_ov), .OutReady(OutReady),
    .AGEB(s_ge), .AEQB(s_eq), .AGTB(s_gt), .ModeErr(s_err),
    .StatClr(StatClr), .GeCount(s_gec), .TotCount(s_totc)
  );
`endif

  assign obs = {AGEB, AEQB, AGTB, ModeErr};

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int decode(input logic [7:0] x, input logic [1:0] m);
    int mag;
    mag = int'({25'b0, x[6:0]});
    case (m)
      2'b01:   return int'($signed(x));
      2'b10:   return x[7] ? -mag : mag;
      default: return int'({24'b0, x});
    endcase
  endfunction

  function automatic cmp_res_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    cmp_res_t r;
    int va, vb;
    va = decode(a, m);
    vb = decode(b, m);
    r.ageb = (va >= vb);
    r.aeqb = (va == vb);
    r.agtb = (va > vb);
    r.mode_err = (m == 2'b11);
    return r;
  endfunction

  always @(posedge CLK)
    if (RST_N && InValid && InReady) exp_q.push_back(model(DataA, DataB, Mode));

  always @(negedge CLK) begin
    cmp_res_t e;
    if (RST_N && OutValid && OutReady) begin
      checks++;
      n_retired++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got=%b with no expected entry", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          failures++;
          $display("FAIL sb_result got=%b exp=%b", obs, e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    int n = 0;
    DataA = a; DataB = b; Mode = m; InValid = 1'b1;
    while (!InReady && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    if (!InReady) begin
      $display("FAIL send_timeout InReady=%b exp=1", InReady);
      $fatal(1, "send stuck");
    end
    @(posedge CLK); #1;
    InValid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while ((exp_q.size() != 0 || OutValid) && n < 40) begin
      @(posedge CLK); #1; n++;
    end
    ok = (exp_q.size() == 0) && !OutValid;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; InValid = 1'b0; OutReady = 1'b0; StatClr = 1'b0;
    DataA = '0; DataB = '0; Mode = '0;
    #12;
    checks++;
    if ({OutValid, obs, GeCount, TotCount} !== '0) begin
      failures++;
      $display("FAIL reset_state ov=%b res=%b ge=%0d tot=%0d exp=all zero", OutValid, obs, GeCount, TotCount);
    end
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", InReady); end
  endtask

  task automatic test_sm_latency();
    bit ok;
    OutReady = 1'b1;
    send(8'h85, 8'h03, MODE_SM);
    checks++;
    if (OutValid !== 1'b0) begin failures++; $display("FAIL sm_early_valid got=%b exp=0", OutValid); end
    @(posedge CLK); #1;
    checks++;
    if ({OutValid, obs} !== 5'b1_0000) begin failures++; $display("FAIL sm_neg_lt got=%b exp=10000", {OutValid, obs}); end
    send(8'h80, 8'h00, MODE_SM);
    @(posedge CLK); #1;
    checks++;
    if ({OutValid, obs} !== 5'b1_1100) begin failures++; $display("FAIL sm_neg_zero got=%b exp=11100", {OutValid, obs}); end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL sm_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_formats();
    logic [1:0] ms [3] = '{MODE_TC, MODE_UNS, MODE_RSV};
    logic [3:0] ex [3] = '{4'b0000, 4'b1010, 4'b1011};
    bit ok;
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(8'h80, 8'h7F, ms[i]);
      @(posedge CLK); #1;
      checks++;
      if (obs !== ex[i]) begin failures++; $display("FAIL fmt_%0d got=%b exp=%b", i, obs, ex[i]); end
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fmt_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int n0;
    bit ok;
    n0 = n_retired;
    OutReady = 1'b0;
    DataA = 8'h10; DataB = 8'h20; Mode = MODE_UNS; InValid = 1'b1;
    @(posedge CLK); #1;
    DataA = 8'h30; DataB = 8'h30;
    checks++;
    if (InReady !== 1'b1) begin failures++; $display("FAIL bp_accept2 got=%b exp=1", InReady); end
    @(posedge CLK); #1;
    DataA = 8'h50; DataB = 8'h40;
    checks++;
    if (InReady !== 1'b0) begin failures++; $display("FAIL bp_stall3 got=%b exp=0", InReady); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checks++;
      if ({OutValid, InReady, obs} !== 6'b10_0000) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%b exp=100000", i, {OutValid, InReady, obs});
      end
    end
    OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", InReady); end
    @(posedge CLK); #1;
    InValid = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok || (n_retired - n0) != 3) begin
      failures++;
      $display("FAIL bp_count retired=%0d exp=3", n_retired - n0);
    end
  endtask

  task automatic test_streaming();
    int n0;
    bit ok;
    n0 = n_retired;
    OutReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      DataA = 8'($urandom);
      DataB = (i % 7 == 0) ? DataA : 8'($urandom);
      Mode  = 2'($urandom_range(0, 3));
      InValid = 1'b1;
      checks++;
      if (InReady !== 1'b1 || (i >= 2 && OutValid !== 1'b1)) begin
        failures++;
        $display("FAIL stream_rate_%0d ir=%b ov=%b exp=1", i, InReady, OutValid);
      end
      @(posedge CLK); #1;
    end
    InValid = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok || (n_retired - n0) != 100) begin
      failures++;
      $display("FAIL stream_count retired=%0d exp=100", n_retired - n0);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    OutReady = 1'b0;
    send(8'h01, 8'h02, MODE_UNS);
    send(8'h03, 8'h04, MODE_UNS);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({OutValid, obs, GeCount, TotCount} !== '0) begin
      failures++;
      $display("FAIL rst_flush ov=%b res=%b ge=%0d tot=%0d exp=all zero", OutValid, obs, GeCount, TotCount);
    end
    exp_q.delete();
    @(negedge CLK); RST_N = 1'b1;
    OutReady = 1'b1;
    send(8'h05, 8'hFB, MODE_TC);
    @(posedge CLK); #1;
    checks++;
    if ({OutValid, obs} !== 5'b1_1010) begin failures++; $display("FAIL rst_first got=%b exp=11010", {OutValid, obs}); end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_drain pending=%0d exp=0", exp_q.size()); end
  endtask

`ifdef CMP_PIPE_STAT_EN
  task automatic test_stats();
    bit ok;
    StatClr = 1'b1;
    @(posedge CLK); #1;
    StatClr = 1'b0;
    checks++;
    if (GeCount !== '0 || TotCount !== '0) begin
      failures++;
      $display("FAIL stat_clear ge=%0d tot=%0d exp=0", GeCount, TotCount);
    end
    OutReady = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(i), 8'h04, MODE_UNS);
    wait_drain(ok);
    checks++;
    if (!ok || TotCount !== 16'd10 || GeCount !== 16'd6) begin
      failures++;
      $display("FAIL stat_count tot=%0d ge=%0d exp tot=10 ge=6", TotCount, GeCount);
    end
    checks++;
    if (s_totc !== 2'd3 || s_gec !== 2'd3) begin
      failures++;
      $display("FAIL stat_saturate tot=%0d ge=%0d exp=3", s_totc, s_gec);
    end
    OutReady = 1'b0;
    send(8'h09, 8'h01, MODE_UNS);
    @(posedge CLK); #1;
    StatClr = 1'b1;
    OutReady = 1'b1;
    @(posedge CLK); #1;
    StatClr = 1'b0;
    checks++;
    if (GeCount !== '0 || TotCount !== '0) begin
      failures++;
      $display("FAIL stat_clr_wins ge=%0d tot=%0d exp=0", GeCount, TotCount);
    end
    wait_drain(ok);
  endtask
`else
  task automatic test_stats();
    StatClr = 1'b1;
    @(posedge CLK); #1;
    StatClr = 1'b0;
    checks++;
    if (GeCount !== '0 || TotCount !== '0) begin
      failures++;
      $display("FAIL stat_tied ge=%0d tot=%0d exp=0", GeCount, TotCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sm_latency();
    test_formats();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    test_stats();
    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
